// File: rtl/shifter_pkg.sv
// Shared encodings for the operand-2 shift path: shift types, sequencer states
// and the fixed ARM word width.
package shifter_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single shift step of 0..32 positions; carry is the last bit
// shifted out, or the incoming carry when nothing moves.
module shift_step_unit
  import shifter_pkg::*;
(
  input  logic [WORD-1:0] data_in,
  input  shift_t          sh_type,
  input  logic [5:0]      s,
  input  logic            carry_in,
  output logic [WORD-1:0] data_out,
  output logic            carry_out
);

  logic [WORD:0]   lsl_w;
  logic [WORD:0]   lsr_w;
  logic [WORD:0]   asr_w;
  logic [WORD-1:0] ror_w;

  // One guard bit above (LSL) or below (LSR/ASR) the word catches the last bit out.
  always_comb begin
    lsl_w = {1'b0, data_in} << s;
    lsr_w = {data_in, 1'b0} >> s;
    asr_w = $signed({data_in, 1'b0}) >>> s;
    ror_w = (data_in >> s) | (data_in << (6'd32 - s));

    data_out  = data_in;
    carry_out = carry_in;
    if (s != 6'd0) begin
      unique case (sh_type)
        SH_LSL: begin
          data_out  = lsl_w[WORD-1:0];
          carry_out = lsl_w[WORD];
        end
        SH_LSR: begin
          data_out  = lsr_w[WORD:1];
          carry_out = lsr_w[0];
        end
        SH_ASR: begin
          data_out  = asr_w[WORD:1];
          carry_out = asr_w[0];
        end
        SH_ROR: begin
          data_out  = ror_w;
          carry_out = ror_w[WORD-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle ARM operand-2 shifter: normalises the amount on start, then walks
// the shift through shift_step_unit STEP bits per cycle.
//   state    | meaning
//   ST_IDLE  | waiting for start; result/carry_out hold the last answer
//   ST_SHIFT | shifting min(cnt,STEP) bits per cycle
//   ST_DONE  | one-cycle done pulse, result/carry_out valid
module shift_sequencer
  import shifter_pkg::*;
#(
  parameter int STEP  = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_data,
  input  logic [1:0]       shift_type,
  input  logic [7:0]       amount,
  input  logic             amount_is_imm,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam logic [5:0] STEP_V = 6'(STEP);

  state_t           state_q, state_d;
  shift_t           type_q, type_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  shift_t           in_type;
  logic [4:0]       amt5;
  logic [5:0]       norm_cnt;
  logic [WIDTH-1:0] zero_res;
  logic             zero_c;
  logic [5:0]       step_s;
  logic [WIDTH-1:0] step_data;
  logic             step_c;

  // A zero norm_cnt means the answer is zero_res/zero_c with no SHIFT cycles.
  always_comb begin
    in_type  = shift_t'(shift_type);
    amt5     = amount[4:0];
    norm_cnt = 6'd0;
    zero_res = op_data;
    zero_c   = carry_in;
    if (amount_is_imm) begin
      unique case (in_type)
        SH_LSL: norm_cnt = {1'b0, amt5};
        SH_LSR, SH_ASR: norm_cnt = (amt5 == 5'd0) ? 6'd32 : {1'b0, amt5};
        SH_ROR: begin
          norm_cnt = {1'b0, amt5};
          if (amt5 == 5'd0) begin
            zero_res = {carry_in, op_data[WIDTH-1:1]};
            zero_c   = op_data[0];
          end
        end
        default: ;
      endcase
    end else if (amount != 8'd0) begin
      unique case (in_type)
        SH_LSL, SH_LSR: norm_cnt = (amount > 8'd33) ? 6'd33 : amount[5:0];
        SH_ASR: norm_cnt = (amount > 8'd32) ? 6'd32 : amount[5:0];
        SH_ROR: begin
          norm_cnt = {1'b0, amt5};
          zero_c   = op_data[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

  assign step_s = (cnt_q < STEP_V) ? cnt_q : STEP_V;

  shift_step_unit u_step (
    .data_in   (data_q),
    .sh_type   (type_q),
    .s         (step_s),
    .carry_in  (carry_q),
    .data_out  (step_data),
    .carry_out (step_c)
  );

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          type_d  = in_type;
          data_d  = op_data;
          carry_d = carry_in;
          cnt_d   = norm_cnt;
          if (norm_cnt == 6'd0) begin
            result_d = zero_res;
            cout_d   = zero_c;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d  = step_data;
        carry_d = step_c;
        cnt_d   = cnt_q - step_s;
        if (cnt_q == step_s) begin
          result_d = step_data;
          cout_d   = step_c;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      type_q   <= SH_LSL;
      data_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against an arithmetic
// model of ARM shifter semantics.
module tb_shift_sequencer;

  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_data = '0;
  logic [1:0]  shift_type = '0;
  logic [7:0]  amount = '0;
  logic        amount_is_imm = 1'b0;
  logic        carry_in = 1'b0;
  logic        busy, done, carry_out;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.STEP(STEP), .WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .op_data       (op_data),
    .shift_type    (shift_type),
    .amount        (amount),
    .amount_is_imm (amount_is_imm),
    .carry_in      (carry_in),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .carry_out     (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {carry, result} from ARM shifter rules.
  function automatic logic [32:0] ref_op(input logic [31:0] op, input logic [1:0] ty,
                                         input logic [7:0] amt, input logic imm, input logic cin);
    int n;
    logic [63:0] wide;
    n = imm ? int'(amt[4:0]) : int'(amt);
    if (n == 0) begin
      if (!imm || ty == 2'd0) return {cin, op};
      if (ty == 2'd3) return {op[0], cin, op[31:1]};
      n = 32;
    end
    case (ty)
      2'd0: begin
        if (n < 32) return {op[32-n], op << n};
        if (n == 32) return {op[0], 32'h0};
        return 33'h0;
      end
      2'd1: begin
        if (n < 32) return {op[n-1], op >> n};
        if (n == 32) return {op[31], 32'h0};
        return 33'h0;
      end
      2'd2: begin
        if (n >= 32) return {op[31], {32{op[31]}}};
        return {op[n-1], 32'($signed(op) >>> n)};
      end
      default: begin
        n = n % 32;
        if (n == 0) return {op[31], op};
        wide = {op, op} >> n;
        return {wide[31], wide[31:0]};
      end
    endcase
  endfunction

  // Number of SHIFT cycles: ceil(cnt/STEP), cnt per the amount normalisation.
  function automatic int ref_k(input logic [1:0] ty, input logic [7:0] amt, input logic imm);
    int cnt;
    if (imm) begin
      cnt = int'(amt[4:0]);
      if (cnt == 0 && (ty == 2'd1 || ty == 2'd2)) cnt = 32;
      if (cnt == 0) return 0;
    end else begin
      cnt = int'(amt);
      if (ty == 2'd3) cnt = cnt % 32;
      else if (ty == 2'd2 && cnt > 32) cnt = 32;
      else if (cnt > 33) cnt = 33;
    end
    return (cnt + STEP - 1) / STEP;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] op, input logic [1:0] ty,
                        input logic [7:0] amt, input logic imm, input logic cin, input logic poke);
    logic [32:0] exp;
    int k, cyc;
    exp = ref_op(op, ty, amt, imm, cin);
    k = ref_k(ty, amt, imm);
    @(negedge clk);
    op_data = op; shift_type = ty; amount = amt; amount_is_imm = imm; carry_in = cin;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, ".busy"}, {31'h0, busy}, 32'h1);
    if (poke) begin
      op_data = $urandom; shift_type = 2'($urandom_range(0, 3));
      amount = 8'($urandom_range(0, 255)); carry_in = ~cin; start = 1'b1;
    end
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(k));
    chk({tag, ".result"}, result, exp[31:0]);
    chk({tag, ".carry"}, {31'h0, carry_out}, {31'h0, exp[32]});
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, {30'h0, done, busy}, 32'h0);
    chk({tag, ".held"}, result, exp[31:0]);
  endtask

  initial begin
    logic [7:0] ra;
    logic [1:0] rt;
    logic       ri;
    #1;
    chk("rst.async", {29'h0, busy, done, carry_out}, 32'h0);
    chk("rst.result", result, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op("t1.lsl4", 32'h0000_00F1, 2'd0, 8'd4, 1'b0, 1'b1, 1'b0);
    run_op("t2.lsr32", 32'h8000_0001, 2'd1, 8'd32, 1'b0, 1'b0, 1'b0);
    run_op("t2.lsl40", 32'h8000_0001, 2'd0, 8'd40, 1'b0, 1'b1, 1'b0);
    run_op("t2.lsl32", 32'h8000_0001, 2'd0, 8'd32, 1'b0, 1'b0, 1'b0);
    run_op("t2.lsr33", 32'hFFFF_FFFF, 2'd1, 8'd33, 1'b0, 1'b1, 1'b0);
    run_op("t3.asr_i0", 32'h8000_0000, 2'd2, 8'd0, 1'b1, 1'b0, 1'b0);
    run_op("t3.ror36", 32'h0000_0012, 2'd3, 8'd36, 1'b0, 1'b1, 1'b0);
    run_op("t3.ror64", 32'h8000_1234, 2'd3, 8'd64, 1'b0, 1'b0, 1'b0);
    run_op("t3.lsr_i0", 32'h8000_0000, 2'd1, 8'hE0, 1'b1, 1'b0, 1'b0);
    run_op("t3.asr200", 32'h4000_0000, 2'd2, 8'd200, 1'b0, 1'b1, 1'b0);
    run_op("t4.rrx", 32'h0000_0003, 2'd3, 8'd0, 1'b1, 1'b1, 1'b0);
    run_op("t4.reg0", 32'h1234_5678, 2'd2, 8'd0, 1'b0, 1'b1, 1'b0);
    run_op("t4.lsl_i0", 32'hCAFE_0001, 2'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    run_op("t5.ignore", 32'h0F0F_1234, 2'd0, 8'd20, 1'b0, 1'b0, 1'b1);
    run_op("t5.ignore_done", 32'h0000_0003, 2'd3, 8'd0, 1'b1, 1'b0, 1'b1);

    // Abort an operation in its second SHIFT cycle.
    @(negedge clk);
    op_data = 32'h8000_0001; shift_type = 2'd1; amount = 8'd32; amount_is_imm = 1'b0;
    carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("t6.pre_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("t6.rst_flags", {29'h0, busy, done, carry_out}, 32'h0);
    chk("t6.rst_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_op("t6.after", 32'h0000_00F1, 2'd0, 8'd4, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rt = 2'($urandom_range(0, 3));
      ri = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: ra = 8'd0;
        1: ra = 8'd32;
        2: ra = 8'd33;
        3: ra = 8'($urandom_range(0, 255));
        4: ra = 8'($urandom_range(1, 40));
        default: ra = 8'($urandom_range(1, 7) << 5);
      endcase
      run_op("rand", $urandom, rt, ra, ri, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
